// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - opcode encodings OP_AND..OP_ACCLD (14 and 15 are reserved)
//   - control FSM states ST_IDLE / ST_MUL / ST_HOLD
//   - is_reserved(): true for opcodes with no defined operation
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOTA  = 4'd5;
  localparam logic [3:0] OP_NOTB  = 4'd6;
  localparam logic [3:0] OP_ZERO  = 4'd7;
  localparam logic [3:0] OP_SHL   = 4'd8;
  localparam logic [3:0] OP_SHR   = 4'd9;
  localparam logic [3:0] OP_SRA   = 4'd10;
  localparam logic [3:0] OP_MUL   = 4'd11;
  localparam logic [3:0] OP_CMP   = 4'd12;
  localparam logic [3:0] OP_ACCLD = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  function automatic logic is_reserved(input logic [3:0] op);
    return (op > OP_ACCLD);
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: unsigned shift-add multiplier, one partial product per cycle.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_start         load operands (iterations begin on the following edges)
//   i_a, i_b        N-bit unsigned operands, captured at the start edge
//   o_last          high during the cycle whose edge performs the final iteration
//   o_prod_next     product after the current iteration (final product while o_last)
//   o_prod          registered product (holds the final product once done)
module alu_mul_seq #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic           o_last,
  output logic [2*N-1:0] o_prod_next,
  output logic [2*N-1:0] o_prod
);

  localparam int CW = $clog2(N);

  logic           r_busy;
  logic [CW-1:0]  r_cnt;
  logic [2*N-1:0] r_mcand;
  logic [N-1:0]   r_mplier;
  logic [2*N-1:0] r_prod;
  logic [2*N-1:0] w_addend;

  assign w_addend    = r_mplier[0] ? r_mcand : '0;
  assign o_prod_next = r_prod + w_addend;
  assign o_last      = r_busy & (r_cnt == CW'(N - 1));
  assign o_prod      = r_prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_mcand  <= {{N{1'b0}}, i_a};
      r_mplier <= i_b;
      r_prod   <= '0;
    end else if (r_busy) begin
      r_prod   <= o_prod_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (o_last) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered N-bit ALU with flags, accumulator and multi-cycle multiply.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid / in_ready  operand handshake (transfer = in_valid & in_ready)
//   a, b, op, use_acc    operands, opcode (alu_pkg), use acc as operand A
//   out_valid/out_ready  result handshake (transfer = out_valid & out_ready)
//   f, f_hi              result (MUL: low / high half; f_hi=0 otherwise)
//   zero,carry,ovf,neg,err  flags registered with f
//   acc                  accumulator
// Single-cycle ops load the output register at the accept edge. MUL runs in
// alu_mul_seq for N cycles; the result loads on the last iteration edge, or
// waits in HOLD if the output slot is still occupied.
module alu_seq
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   op,
  input  logic         use_acc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] f,
  output logic [N-1:0] f_hi,
  output logic         zero,
  output logic         carry,
  output logic         ovf,
  output logic         neg,
  output logic         err,
  output logic [N-1:0] acc
);

  localparam int SW = $clog2(N);

  state_t r_state, w_state_nxt;

  logic         r_vld_p1;
  logic [N-1:0] r_f_p1, r_fhi_p1, r_acc;
  logic         r_z_p1, r_c_p1, r_v_p1, r_n_p1, r_e_p1;

  logic                w_accept, w_slot_free, w_mul_start;
  logic [N-1:0]        w_opa;
  logic [SW-1:0]       w_amt;
  logic [N:0]          w_sum, w_diff, w_shl, w_shr;
  logic signed [N:0]   w_sra;

  // single-cycle result
  logic [N-1:0] w_sc_f, w_sc_acc;
  logic         w_sc_z, w_sc_c, w_sc_v, w_sc_n, w_sc_e, w_sc_accwr;

  // multiplier interface
  logic           w_mul_last;
  logic [2*N-1:0] w_mul_next, w_mul_prod, w_mul_p;

  // selected load
  logic         w_ld;
  logic [N-1:0] w_ld_f, w_ld_fhi, w_ld_acc;
  logic         w_ld_z, w_ld_c, w_ld_v, w_ld_n, w_ld_e, w_ld_accwr;

  assign w_slot_free = ~r_vld_p1 | out_ready;
  assign in_ready    = (r_state == ST_IDLE) & ~rst & w_slot_free;
  assign w_accept    = in_valid & in_ready;
  assign w_mul_start = w_accept & (op == OP_MUL);

  assign w_opa  = (use_acc && (op != OP_ACCLD)) ? r_acc : a;
  assign w_amt  = b[SW-1:0];
  assign w_sum  = {1'b0, w_opa} + {1'b0, b};
  assign w_diff = {1'b0, w_opa} - {1'b0, b};
  // Shifts carry one guard bit so the last bit shifted out lands at a fixed
  // position; with amount 0 the guard bit stays 0.
  assign w_shl  = {1'b0, w_opa} << w_amt;
  assign w_shr  = {w_opa, 1'b0} >> w_amt;
  assign w_sra  = $signed({w_opa, 1'b0}) >>> w_amt;

  alu_mul_seq #(.N(N)) u_mul (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_mul_start),
    .i_a         (w_opa),
    .i_b         (b),
    .o_last      (w_mul_last),
    .o_prod_next (w_mul_next),
    .o_prod      (w_mul_prod)
  );

  always_comb begin
    w_sc_f     = '0;
    w_sc_c     = 1'b0;
    w_sc_v     = 1'b0;
    w_sc_e     = 1'b0;
    w_sc_accwr = 1'b1;
    w_sc_acc   = '0;
    case (op)
      OP_AND:  w_sc_f = w_opa & b;
      OP_OR:   w_sc_f = w_opa | b;
      OP_ADD: begin
        w_sc_f = w_sum[N-1:0];
        w_sc_c = w_sum[N];
        w_sc_v = (w_opa[N-1] == b[N-1]) & (w_sum[N-1] != w_opa[N-1]);
      end
      OP_SUB, OP_CMP: begin
        w_sc_f = (op == OP_SUB) ? w_diff[N-1:0] : '0;
        w_sc_c = w_diff[N];
        w_sc_v = (w_opa[N-1] != b[N-1]) & (w_diff[N-1] != w_opa[N-1]);
      end
      OP_XOR:  w_sc_f = w_opa ^ b;
      OP_NOTA: w_sc_f = ~w_opa;
      OP_NOTB: w_sc_f = ~b;
      OP_ZERO: w_sc_f = '0;
      OP_SHL: begin
        w_sc_f = w_shl[N-1:0];
        w_sc_c = w_shl[N];
      end
      OP_SHR: begin
        w_sc_f = w_shr[N:1];
        w_sc_c = w_shr[0];
      end
      OP_SRA: begin
        w_sc_f = w_sra[N:1];
        w_sc_c = w_sra[0];
      end
      OP_ACCLD: w_sc_f = a;
      default: w_sc_e = 1'b1;
    endcase
    w_sc_z = (w_sc_f == '0);
    w_sc_n = w_sc_f[N-1];
    if (op == OP_CMP) begin
      w_sc_z     = (w_diff[N-1:0] == '0);
      w_sc_n     = w_diff[N-1];
      w_sc_accwr = 1'b0;
    end
    if (is_reserved(op)) begin
      w_sc_z     = 1'b0;
      w_sc_n     = 1'b0;
      w_sc_accwr = 1'b0;
    end
    w_sc_acc = (op == OP_ACCLD) ? a : w_sc_f;
  end

  // In MUL the final product is still combinational; in HOLD it is registered.
  assign w_mul_p = (r_state == ST_MUL) ? w_mul_next : w_mul_prod;

  always_comb begin
    w_state_nxt = r_state;
    w_ld        = 1'b0;
    w_ld_f      = w_sc_f;
    w_ld_fhi    = '0;
    w_ld_z      = w_sc_z;
    w_ld_c      = w_sc_c;
    w_ld_v      = w_sc_v;
    w_ld_n      = w_sc_n;
    w_ld_e      = w_sc_e;
    w_ld_accwr  = w_sc_accwr;
    w_ld_acc    = w_sc_acc;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (op == OP_MUL) w_state_nxt = ST_MUL;
          else              w_ld        = 1'b1;
        end
      end
      ST_MUL, ST_HOLD: begin
        w_ld_f     = w_mul_p[N-1:0];
        w_ld_fhi   = w_mul_p[2*N-1:N];
        w_ld_z     = (w_mul_p[N-1:0] == '0);
        w_ld_c     = (w_mul_p[2*N-1:N] != '0);
        w_ld_v     = 1'b0;
        w_ld_n     = w_mul_p[2*N-1];
        w_ld_e     = 1'b0;
        w_ld_accwr = 1'b1;
        w_ld_acc   = w_mul_p[N-1:0];
        if (r_state == ST_MUL) begin
          if (w_mul_last) begin
            if (w_slot_free) begin
              w_ld        = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_state_nxt = ST_HOLD;
            end
          end
        end else if (out_ready) begin
          w_ld        = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
      r_f_p1   <= '0;
      r_fhi_p1 <= '0;
      r_z_p1   <= 1'b0;
      r_c_p1   <= 1'b0;
      r_v_p1   <= 1'b0;
      r_n_p1   <= 1'b0;
      r_e_p1   <= 1'b0;
      r_acc    <= '0;
    end else begin
      if (w_ld) begin
        r_vld_p1 <= 1'b1;
        r_f_p1   <= w_ld_f;
        r_fhi_p1 <= w_ld_fhi;
        r_z_p1   <= w_ld_z;
        r_c_p1   <= w_ld_c;
        r_v_p1   <= w_ld_v;
        r_n_p1   <= w_ld_n;
        r_e_p1   <= w_ld_e;
        if (w_ld_accwr) r_acc <= w_ld_acc;
      end else if (out_ready) begin
        r_vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid = r_vld_p1;
  assign f         = r_f_p1;
  assign f_hi      = r_fhi_p1;
  assign zero      = r_z_p1;
  assign carry     = r_c_p1;
  assign ovf       = r_v_p1;
  assign neg       = r_n_p1;
  assign err       = r_e_p1;
  assign acc       = r_acc;

endmodule
